// File: rtl/serial_addsub.sv
// serial_addsub: bit-serial adder/subtractor, one full-adder slice plus a
// carry flop, one bit per clock LSB first, with start/busy/done handshake.
//
// Ports:
//   clk    rising-edge clock
//   rst    synchronous reset, active-high
//   start  request a new operation (sampled only when not busy)
//   SUB    0: A+B+CIN, 1: A-B (CIN ignored); captured at start
//   CIN    carry-in for add mode; captured at start
//   A, B   operands; captured at start
//   busy   operation in progress
//   done   one-cycle pulse when S/C/OVF have just been updated
//   S      registered result, held until the next completion
//   C      carry-out (no-borrow in subtract mode)
//   OVF    two's-complement overflow

module serial_addsub #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             SUB,
    input  logic             CIN,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             C,
    output logic             OVF
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cy_q, cy_d;
    logic             c_q, c_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Full-adder slice: two half-adder stages.
    logic ha1_s, ha1_c, ha2_c;
    logic bit_sum, bit_cy, last;

    always_comb begin
        ha1_s   = a_q[0] ^ b_q[0];
        ha1_c   = a_q[0] & b_q[0];
        bit_sum = ha1_s ^ cy_q;
        ha2_c   = ha1_s & cy_q;
        bit_cy  = ha1_c | ha2_c;
        last    = (cnt_q == CNT_W'(WIDTH - 1));
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        s_d     = s_q;
        cnt_d   = cnt_q;
        cy_d    = cy_q;
        c_d     = c_q;
        ovf_d   = ovf_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    // Subtract is A + ~B + 1: invert B, force carry-in.
                    a_d     = A;
                    b_d     = B ^ {WIDTH{SUB}};
                    cy_d    = SUB | CIN;
                    cnt_d   = '0;
                    state_d = RUN;
                    busy_d  = 1'b1;
                end
            end
            RUN: begin
                r_d            = r_q >> 1;
                r_d[WIDTH-1]   = bit_sum;
                a_d            = a_q >> 1;
                b_d            = b_q >> 1;
                cy_d           = bit_cy;
                cnt_d          = cnt_q + CNT_W'(1);
                busy_d         = 1'b1;
                if (last) begin
                    // cy_q here is the carry into the MSB.
                    s_d     = r_d;
                    c_d     = bit_cy;
                    ovf_d   = cy_q ^ bit_cy;
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            s_q     <= '0;
            cnt_q   <= '0;
            cy_q    <= 1'b0;
            c_q     <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
            cy_q    <= cy_d;
            c_q     <= c_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign S    = s_q;
    assign C    = c_q;
    assign OVF  = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// tb_serial_addsub: table-driven and hand-sequenced checks of serial_addsub
// at WIDTH=8 and WIDTH=1, with a queue of expected results.

module tb_serial_addsub;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start8, sub8, cin8;
    logic [7:0] a8, b8;
    logic       busy8, done8, c8, ovf8;
    logic [7:0] s8;

    logic       start1, sub1, cin1;
    logic [0:0] a1, b1;
    logic       busy1, done1, c1, ovf1;
    logic [0:0] s1;

    serial_addsub #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .start(start8), .SUB(sub8), .CIN(cin8),
        .A(a8), .B(b8), .busy(busy8), .done(done8), .S(s8), .C(c8),
        .OVF(ovf8)
    );

    serial_addsub #(.WIDTH(1)) u1 (
        .clk(clk), .rst(rst), .start(start1), .SUB(sub1), .CIN(cin1),
        .A(a1), .B(b1), .busy(busy1), .done(done1), .S(s1), .C(c1),
        .OVF(ovf1)
    );

    typedef struct packed {
        logic [7:0] s;
        logic       c;
        logic       ovf;
    } res_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       sub;
        logic       cin;
        res_t       exp;
    } vec_t;

    res_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // Wait for done on the selected DUT, then pop and compare.
    task automatic finish_op(input string name, input bit w1,
                             input int lat);
        int   k;
        res_t e;
        logic d;
        k = 0;
        d = 1'b0;
        while (!d && k < 40) begin
            @(negedge clk);
            k++;
            d = w1 ? done1 : done8;
        end
        if (!d) begin
            chk({name, " timeout"}, 0, 1);
            return;
        end
        chk({name, " latency"}, k, lat);
        if (exp_q.size() == 0) begin
            chk({name, " unexpected done"}, 0, 1);
            return;
        end
        e = exp_q.pop_front();
        if (w1) begin
            chk({name, " S"}, {31'd0, s1}, {24'd0, e.s});
            chk({name, " C"}, {31'd0, c1}, {31'd0, e.c});
            chk({name, " OVF"}, {31'd0, ovf1}, {31'd0, e.ovf});
        end else begin
            chk({name, " S"}, {24'd0, s8}, {24'd0, e.s});
            chk({name, " C"}, {31'd0, c8}, {31'd0, e.c});
            chk({name, " OVF"}, {31'd0, ovf8}, {31'd0, e.ovf});
        end
    endtask

    task automatic run8(input string name, input vec_t v);
        exp_q.push_back(v.exp);
        a8     = v.a;
        b8     = v.b;
        sub8   = v.sub;
        cin8   = v.cin;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        a8     = ~v.a;
        b8     = ~v.b;
        chk({name, " busy"}, {31'd0, busy8}, 1);
        finish_op(name, 1'b0, 8);
        @(negedge clk);
        chk({name, " done pulse"}, {31'd0, done8}, 0);
    endtask

    vec_t vecs[8];

    initial begin
        int   seen;
        res_t e1;
        logic ta, tb, tc, ts, tcarry;

        vecs[0] = '{8'h3C, 8'h55, 1'b0, 1'b0, '{8'h91, 1'b0, 1'b1}};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 1'b1, '{8'h01, 1'b1, 1'b0}};
        vecs[2] = '{8'h10, 8'h20, 1'b1, 1'b0, '{8'hF0, 1'b0, 1'b0}};
        vecs[3] = '{8'h80, 8'h01, 1'b1, 1'b0, '{8'h7F, 1'b1, 1'b1}};
        vecs[4] = '{8'h55, 8'h55, 1'b1, 1'b0, '{8'h00, 1'b1, 1'b0}};
        vecs[5] = '{8'h7F, 8'h01, 1'b0, 1'b0, '{8'h80, 1'b0, 1'b1}};
        vecs[6] = '{8'h00, 8'h01, 1'b1, 1'b0, '{8'hFF, 1'b0, 1'b0}};
        vecs[7] = '{8'h05, 8'h03, 1'b1, 1'b1, '{8'h02, 1'b1, 1'b0}};

        // Reset held 2 cycles with start asserted.
        rst    = 1'b1;
        start8 = 1'b1;
        a8     = 8'h3C;
        b8     = 8'h55;
        sub8   = 1'b0;
        cin8   = 1'b0;
        start1 = 1'b0;
        a1     = 1'b0;
        b1     = 1'b0;
        sub1   = 1'b0;
        cin1   = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst busy", {31'd0, busy8}, 0);
        chk("rst done", {31'd0, done8}, 0);
        chk("rst S", {24'd0, s8}, 0);
        chk("rst C", {31'd0, c8}, 0);
        chk("rst OVF", {31'd0, ovf8}, 0);
        rst    = 1'b0;
        start8 = 1'b0;
        @(negedge clk);
        chk("post-rst idle", {30'd0, busy8, done8}, 0);

        for (int i = 0; i < 8; i++)
            run8($sformatf("vec%0d", i), vecs[i]);

        // start re-pulsed at E3, operands changed at E4.
        exp_q.push_back('{8'h46, 1'b0, 1'b0});
        a8     = 8'h12;
        b8     = 8'h34;
        sub8   = 1'b0;
        cin8   = 1'b0;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (2) @(negedge clk);
        start8 = 1'b1;
        a8     = 8'hAA;
        b8     = 8'hBB;
        sub8   = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        a8     = 8'h01;
        b8     = 8'h02;
        finish_op("restart ignored", 1'b0, 5);
        @(negedge clk);
        chk("restart no extra", {30'd0, busy8, done8}, 0);

        // start held through DONE: back-to-back operations.
        exp_q.push_back('{8'h03, 1'b0, 1'b0});
        a8     = 8'h01;
        b8     = 8'h02;
        sub8   = 1'b0;
        cin8   = 1'b0;
        start8 = 1'b1;
        @(negedge clk);
        a8 = 8'h70;
        b8 = 8'h20;
        exp_q.push_back('{8'h90, 1'b0, 1'b1});
        finish_op("b2b first", 1'b0, 8);
        @(negedge clk);
        start8 = 1'b0;
        chk("b2b busy", {31'd0, busy8}, 1);
        finish_op("b2b second", 1'b0, 8);
        @(negedge clk);
        chk("b2b end", {30'd0, busy8, done8}, 0);

        // Mid-operation reset at E4.
        run8("pre-abort", vecs[1]);
        a8     = 8'h3C;
        b8     = 8'h55;
        sub8   = 1'b0;
        cin8   = 1'b0;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        chk("S held in run", {24'd0, s8}, 32'h01);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort busy", {31'd0, busy8}, 0);
        chk("abort S", {24'd0, s8}, 0);
        chk("abort C/OVF", {30'd0, c8, ovf8}, 0);
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (done8) seen++;
        end
        chk("abort no done", seen, 0);

        // WIDTH=1 exhaustive over {SUB, CIN, B, A}.
        for (int i = 0; i < 16; i++) begin
            ta = i[0];
            tb = i[1];
            tc = i[2];
            if (i[3]) begin
                ts     = ta ^ tb;
                tcarry = ta | ~tb;
                e1     = '{{7'd0, ts}, tcarry, 1'b1 ^ tcarry};
            end else begin
                ts     = ta ^ tb ^ tc;
                tcarry = (ta & tb) | (ta & tc) | (tb & tc);
                e1     = '{{7'd0, ts}, tcarry, tc ^ tcarry};
            end
            exp_q.push_back(e1);
            a1     = ta;
            b1     = tb;
            cin1   = tc;
            sub1   = i[3];
            start1 = 1'b1;
            @(negedge clk);
            start1 = 1'b0;
            finish_op($sformatf("w1 case%0d", i), 1'b1, 1);
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
